// File: rtl/regfile_access_master.sv
`default_nettype none
// ============================================================================
// Module   : regfile_access_master
// Brief    : Command-driven initiator for the 32x32 register file: single-word
//            writes and burst reads with a backpressured response channel.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_access_master #(
  parameter int   RD_LAT    = 1,
  parameter logic SCRIBBLE  = 1'b0,
  parameter logic INTERPRET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_addr,
  input  logic [5:0]  cmd_len,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_addr,
  output logic        rsp_last,
  output logic        rf_write_enable,
  output logic        rf_mode,
  output logic [4:0]  rf_address,
  output logic [31:0] rf_data_in,
  input  logic [31:0] rf_data_out,
  output logic        busy
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_WR       = 3'd1;
  localparam logic [2:0] c_RD_ISSUE = 3'd2;
  localparam logic [2:0] c_RD_WAIT  = 3'd3;
  localparam logic [2:0] c_RD_RESP  = 3'd4;

  localparam logic [2:0] c_WAIT_INIT = 3'(RD_LAT);

  logic [2:0] r_state;
  logic [2:0] w_next_state;
  logic [5:0] r_remaining;
  logic [2:0] r_wait_cnt;

  logic w_accept;
  logic w_rsp_hs;
  logic w_capture;
  logic w_rf_we_nxt;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (cmd_valid) begin
          w_next_state = cmd_write ? c_WR : c_RD_ISSUE;
        end
      end
      c_WR:       w_next_state = c_IDLE;
      c_RD_ISSUE: w_next_state = c_RD_WAIT;
      c_RD_WAIT: begin
        if (r_wait_cnt == 3'd1) begin
          w_next_state = c_RD_RESP;
        end
      end
      c_RD_RESP: begin
        if (rsp_ready) begin
          w_next_state = rsp_last ? c_IDLE : c_RD_ISSUE;
        end
      end
      default:    w_next_state = c_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    cmd_ready   = (r_state == c_IDLE);
    busy        = (r_state != c_IDLE);
    w_accept    = cmd_valid && (r_state == c_IDLE);
    w_rsp_hs    = rsp_valid && rsp_ready;
    w_capture   = (r_state == c_RD_WAIT) && (r_wait_cnt == 3'd1);
    // Register-file strobes are registered from the next state so they line
    // up exactly with the WR cycle.
    w_rf_we_nxt = (w_next_state == c_WR);
  end

  // rf_address doubles as the current burst address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_write_enable <= 1'b0;
      rf_mode         <= INTERPRET;
      rf_address      <= 5'd0;
      rf_data_in      <= 32'd0;
      r_remaining     <= 6'd0;
      r_wait_cnt      <= 3'd0;
      rsp_valid       <= 1'b0;
      rsp_data        <= 32'd0;
      rsp_addr        <= 5'd0;
      rsp_last        <= 1'b0;
    end else begin
      rf_write_enable <= w_rf_we_nxt;
      rf_mode         <= w_rf_we_nxt ? SCRIBBLE : INTERPRET;

      if (w_accept) begin
        rf_address <= cmd_addr;
        if (cmd_write) begin
          rf_data_in <= cmd_wdata;
        end else begin
          r_remaining <= (cmd_len == 6'd0) ? 6'd32 : cmd_len;
        end
      end else if (w_rsp_hs) begin
        rf_address  <= rf_address + 5'd1;
        r_remaining <= r_remaining - 6'd1;
      end

      if (r_state == c_RD_ISSUE) begin
        r_wait_cnt <= c_WAIT_INIT;
      end else if (r_state == c_RD_WAIT) begin
        r_wait_cnt <= r_wait_cnt - 3'd1;
      end

      if (w_capture) begin
        rsp_valid <= 1'b1;
        rsp_data  <= rf_data_out;
        rsp_addr  <= rf_address;
        rsp_last  <= (r_remaining == 6'd1);
      end else if (w_rsp_hs) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_access_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_access_master
// Brief    : Directed self-checking bench for regfile_access_master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_access_master;

  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [4:0]  cmd_addr = 5'd0;
  logic [5:0]  cmd_len = 6'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_addr;
  logic        rsp_last;
  logic        rf_write_enable;
  logic        rf_mode;
  logic [4:0]  rf_address;
  logic [31:0] rf_data_in;
  logic [31:0] rf_data_out;
  logic        busy;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] mem [32];
  logic [4:0]  got_addr [32];
  logic [31:0] got_data [32];
  logic        got_last [32];
  int          first_lat;
  int          timeouts;
  bit          illegal_we;

  always #5 clk = ~clk;

  regfile_access_master #(.RD_LAT(RD_LAT), .SCRIBBLE(1'b0), .INTERPRET(1'b1)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_last(rsp_last),
    .rf_write_enable(rf_write_enable), .rf_mode(rf_mode),
    .rf_address(rf_address), .rf_data_in(rf_data_in),
    .rf_data_out(rf_data_out), .busy(busy)
  );

  // Register file model with a one-cycle read latency.
  always @(posedge clk) begin
    if (rf_write_enable && rf_mode == 1'b0) mem[rf_address] <= rf_data_in;
    rf_data_out <= mem[rf_address];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    case (a)
      5'd3:    return 32'h11;
      5'd4:    return 32'h22;
      5'd5:    return 32'h33;
      default: return 32'hC0DE_0000 | {27'd0, a};
    endcase
  endfunction

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_wdata = d;
    tick;
    cmd_valid = 1'b0;
    tick;
  endtask

  task automatic issue_read(input logic [4:0] a, input logic [5:0] l);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = l;
    tick;
    cmd_valid = 1'b0;
  endtask

  // Collects n response words, assuming rsp_ready is already high.
  task automatic collect_burst(input int n);
    int lat;
    int guard;
    lat = 1; timeouts = 0; illegal_we = 0; first_lat = -1;
    for (int k = 0; k < n; k++) begin
      guard = 0;
      while (!rsp_valid && guard < 20) begin
        if (rf_write_enable || rf_mode !== 1'b1) illegal_we = 1;
        tick; lat++; guard++;
      end
      if (!rsp_valid) begin
        timeouts++;
        break;
      end
      if (k == 0) first_lat = lat;
      got_addr[k] = rsp_addr; got_data[k] = rsp_data; got_last[k] = rsp_last;
      tick; lat++;
    end
  endtask

  task automatic test_reset;
    tick; tick;
    vectors++;
    if ({rf_write_enable, rf_mode, rf_address, rf_data_in} !== {1'b0, 1'b1, 5'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_rf: got we=%b mode=%b addr=%0d din=%h, want 0 1 0 0",
               rf_write_enable, rf_mode, rf_address, rf_data_in);
    end
    vectors++;
    if ({rsp_valid, rsp_data, rsp_addr, rsp_last, busy} !== {1'b0, 32'd0, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_rsp: got v=%b d=%h a=%0d l=%b busy=%b, want all 0",
               rsp_valid, rsp_data, rsp_addr, rsp_last, busy);
    end
    reset = 1'b0;
    tick;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_write;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd5; cmd_wdata = 32'hDEADBEEF;
    tick;
    cmd_valid = 1'b0;
    vectors++;
    if ({rf_write_enable, rf_mode, rf_address, rf_data_in, cmd_ready} !==
        {1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0}) begin
      errors++;
      $display("FAIL write_cycle: got we=%b mode=%b addr=%0d din=%h rdy=%b, want 1 0 5 deadbeef 0",
               rf_write_enable, rf_mode, rf_address, rf_data_in, cmd_ready);
    end
    tick;
    vectors++;
    if ({rf_write_enable, rf_mode, cmd_ready, rsp_valid} !== {1'b0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL write_after: got we=%b mode=%b rdy=%b rspv=%b, want 0 1 1 0",
               rf_write_enable, rf_mode, cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_read_basic;
    rsp_ready = 1'b1;
    issue_read(5'd3, 6'd3);
    collect_burst(3);
    vectors++;
    if (timeouts !== 0 || illegal_we) begin
      errors++; $display("FAIL basic_flow: timeouts=%0d illegal_we=%b, want 0 0", timeouts, illegal_we);
    end
    vectors++;
    if (first_lat !== 3) begin
      errors++; $display("FAIL basic_latency: got %0d cycles want 3", first_lat);
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({got_addr[k], got_data[k], got_last[k]} !== {5'(3 + k), exp_data(5'(3 + k)), k == 2}) begin
        errors++;
        $display("FAIL basic_word%0d: got a=%0d d=%h l=%b want a=%0d d=%h l=%b", k,
                 got_addr[k], got_data[k], got_last[k], 3 + k, exp_data(5'(3 + k)), k == 2);
      end
    end
  endtask

  task automatic test_read_wrap;
    logic [4:0] ea;
    issue_read(5'd30, 6'd4);
    collect_burst(4);
    vectors++;
    if (timeouts !== 0) begin
      errors++; $display("FAIL wrap_timeout: got %0d want 0", timeouts);
    end
    for (int k = 0; k < 4; k++) begin
      ea = 5'(30 + k);
      vectors++;
      if ({got_addr[k], got_data[k], got_last[k]} !== {ea, exp_data(ea), k == 3}) begin
        errors++;
        $display("FAIL wrap_word%0d: got a=%0d d=%h l=%b want a=%0d d=%h l=%b", k,
                 got_addr[k], got_data[k], got_last[k], ea, exp_data(ea), k == 3);
      end
    end
  endtask

  task automatic test_read_full;
    int bad;
    bad = 0;
    issue_read(5'd0, 6'd0);
    collect_burst(32);
    vectors++;
    if (timeouts !== 0 || illegal_we) begin
      errors++; $display("FAIL full_flow: timeouts=%0d illegal_we=%b, want 0 0", timeouts, illegal_we);
    end
    for (int k = 0; k < 32; k++) begin
      vectors++;
      if ({got_addr[k], got_data[k], got_last[k]} !== {5'(k), exp_data(5'(k)), k == 31}) begin
        errors++;
        $display("FAIL full_word%0d: got a=%0d d=%h l=%b want a=%0d d=%h l=%b", k,
                 got_addr[k], got_data[k], got_last[k], k, exp_data(5'(k)), k == 31);
      end
    end
    vectors++;
    if ({busy, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL full_idle: got busy=%b rdy=%b want 0 1", busy, cmd_ready);
    end
  endtask

  task automatic test_backpressure;
    int  guard;
    bit  stable;
    rsp_ready = 1'b0;
    issue_read(5'd10, 6'd2);
    guard = 0;
    while (!rsp_valid && guard < 20) begin tick; guard++; end
    vectors++;
    if ({rsp_valid, rsp_addr, rsp_data, rsp_last} !== {1'b1, 5'd10, exp_data(5'd10), 1'b0}) begin
      errors++;
      $display("FAIL bp_first: got v=%b a=%0d d=%h l=%b want 1 10 %h 0",
               rsp_valid, rsp_addr, rsp_data, rsp_last, exp_data(5'd10));
    end
    stable = 1;
    repeat (5) begin
      tick;
      if ({rsp_valid, rsp_addr, rsp_data, rf_address} !== {1'b1, 5'd10, exp_data(5'd10), 5'd10})
        stable = 0;
    end
    vectors++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_hold: got v=%b a=%0d d=%h rf_addr=%0d want 1 10 %h 10",
               rsp_valid, rsp_addr, rsp_data, rf_address, exp_data(5'd10));
    end
    rsp_ready = 1'b1;
    tick;
    collect_burst(1);
    vectors++;
    if (timeouts !== 0 || {got_addr[0], got_data[0], got_last[0]} !== {5'd11, exp_data(5'd11), 1'b1}) begin
      errors++;
      $display("FAIL bp_second: timeouts=%0d got a=%0d d=%h l=%b want 11 %h 1",
               timeouts, got_addr[0], got_data[0], got_last[0], exp_data(5'd11));
    end
  endtask

  task automatic test_reset_mid_burst;
    bit stray;
    rsp_ready = 1'b1;
    issue_read(5'd20, 6'd4);
    tick;
    reset = 1'b1;
    #1;
    vectors++;
    if ({rsp_valid, rf_write_enable, rf_mode, busy} !== {1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midrst_async: got rspv=%b we=%b mode=%b busy=%b want 0 0 1 0",
               rsp_valid, rf_write_enable, rf_mode, busy);
    end
    tick; tick;
    reset = 1'b0;
    tick;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_ready: got %b want 1", cmd_ready);
    end
    stray = 0;
    repeat (10) begin
      if (rsp_valid || rf_write_enable || busy) stray = 1;
      tick;
    end
    vectors++;
    if (stray) begin
      errors++; $display("FAIL midrst_stray: activity seen after reset release");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_write;
    for (int i = 0; i < 32; i++) do_write(5'(i), 32'hC0DE_0000 | i);
    do_write(5'd3, 32'h11);
    do_write(5'd4, 32'h22);
    do_write(5'd5, 32'h33);
    test_read_basic;
    test_read_wrap;
    test_read_full;
    test_backpressure;
    test_reset_mid_burst;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
